// File: rtl/xm_pkg.sv
// Shared types and constants for the execute-to-memory stage.
package xm_pkg;

   localparam logic [4:0]  RSTATUS_REG = 5'd30;
   localparam logic [31:0] EXC_MULT    = 32'd4;
   localparam logic [31:0] EXC_DIV     = 32'd5;
   localparam logic [4:0]  ALUOP_MULT  = 5'd6;
   localparam logic [4:0]  ALUOP_DIV   = 5'd7;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] result;
      logic [31:0] store;
      logic [4:0]  rd;
      logic        wen;
   } xm_entry_t;

endpackage

// File: rtl/xm_exc_remap.sv
// Turns mult/div exceptions into a status-register write and suppresses writes to r0.
module xm_exc_remap
   import xm_pkg::*;
(
   input  logic [31:0] instr,
   input  logic [4:0]  aluop,
   input  logic [31:0] result,
   input  logic [31:0] store,
   input  logic [4:0]  rd,
   input  logic        wen,
   input  logic        mult_exc,
   input  logic        div_exc,
   output xm_entry_t   entry,
   output logic        fired
);

   logic mult_hit;
   logic div_hit;

   // When both flags are raised on a divide opcode the multiply code still wins.
   always_comb begin
      mult_hit = mult_exc && ((aluop == ALUOP_MULT) || ((aluop == ALUOP_DIV) && div_exc));
      div_hit  = !mult_hit && div_exc && (aluop == ALUOP_DIV);
      fired    = mult_hit || div_hit;

      entry.instr  = instr;
      entry.store  = store;
      entry.rd     = rd;
      entry.result = result;
      entry.wen    = wen;
      if (mult_hit) begin
         entry.rd     = RSTATUS_REG;
         entry.result = EXC_MULT;
         entry.wen    = 1'b1;
      end else if (div_hit) begin
         entry.rd     = RSTATUS_REG;
         entry.result = EXC_DIV;
         entry.wen    = 1'b1;
      end
      if (entry.rd == 5'd0) entry.wen = 1'b0;
   end

endmodule

// File: rtl/xm_stage.sv
// Execute-to-memory stage with a 2-entry skid buffer and registered in_ready.
// Define XM_EXC_COUNT_EN to add the saturating exc_count output.
module xm_stage
   import xm_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   input  logic [4:0]  in_aluop,
   input  logic [31:0] in_result,
   input  logic [31:0] in_store,
   input  logic [4:0]  in_rd,
   input  logic        in_wen,
   input  logic        in_mult_exc,
   input  logic        in_div_exc,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_result,
   output logic [31:0] out_store,
   output logic [4:0]  out_rd,
   output logic        out_wen
`ifdef XM_EXC_COUNT_EN
   ,
   output logic [CNT_W-1:0] exc_count
`endif
);

   xm_entry_t  head;
   xm_entry_t  tail;
   xm_entry_t  new_entry;
   logic       remap_fired;
   logic [1:0] count;
   logic [1:0] count_next;
   logic       accept;
   logic       pop;

   xm_exc_remap u_remap (
      .instr    (in_instr),
      .aluop    (in_aluop),
      .result   (in_result),
      .store    (in_store),
      .rd       (in_rd),
      .wen      (in_wen),
      .mult_exc (in_mult_exc),
      .div_exc  (in_div_exc),
      .entry    (new_entry),
      .fired    (remap_fired)
   );

   assign out_valid  = (count != 2'd0);
   assign out_instr  = head.instr;
   assign out_result = head.result;
   assign out_store  = head.store;
   assign out_rd     = head.rd;
   assign out_wen    = head.wen;

   // in_ready is a flop, so accept only ever depends on registered state plus flush.
   always_comb begin
      accept = in_valid && in_ready && !flush;
      pop    = out_valid && out_ready;
      if (flush) begin
         count_next = 2'd0;
      end else begin
         unique case ({accept, pop})
            2'b10:   count_next = count + 2'd1;
            2'b01:   count_next = count - 2'd1;
            default: count_next = count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count    <= 2'd0;
         in_ready <= 1'b1;
         head     <= '0;
         tail     <= '0;
      end else begin
         count    <= count_next;
         in_ready <= (count_next < 2'(DEPTH));
         // A full buffer never accepts, so a pop only refills head from tail or from the input.
         if (pop) begin
            if (count == 2'd2) head <= tail;
            else if (accept)   head <= new_entry;
         end else if (accept) begin
            if (count == 2'd0) head <= new_entry;
            else               tail <= new_entry;
         end
      end
   end

`ifdef XM_EXC_COUNT_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         exc_count <= '0;
      end else if (accept && remap_fired && (exc_count != {CNT_W{1'b1}})) begin
         exc_count <= exc_count + 1'b1;
      end
   end
`else
   logic [CNT_W-1:0] unused_cnt;
   logic             unused_fired;
   assign unused_cnt   = '0;
   assign unused_fired = remap_fired;
`endif

endmodule

// File: doc/xm_stage.md
# xm_stage

Execute-to-memory pipeline stage for the pipelined processor. Captures each ALU result together with its instruction and store data, remaps multiply/divide exceptions into a write of an exception code to the status register, and holds results in a 2-entry skid buffer. The buffer uses a valid/ready handshake so that a memory-stage stall never combinationally stalls the execute stage.

## Interface
Parameters:
- DEPTH, 2, skid entries; fixed at 2, other values unsupported
- CNT_W, 16, width of the optional exception counter

Ports (clock and reset first):
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  execute stage presents an instruction
- in_ready  out  1  stage can accept; registered
- in_instr  in  32  instruction word
- in_aluop  in  5  ALU opcode used for this instruction
- in_result  in  32  ALU data_result
- in_store  in  32  operand B (store data)
- in_rd  in  5  destination register
- in_wen  in  1  instruction writes rd
- in_mult_exc  in  1  ALU mult_exception
- in_div_exc  in  1  ALU div_exception
- flush  in  1  kill all buffered and incoming entries
- out_valid  out  1  head entry valid
- out_ready  in  1  memory stage consumes head
- out_instr, out_result, out_store  out  32  head payload
- out_rd  out  5  head destination
- out_wen  out  1  head write enable
- exc_count  out  CNT_W  exception count (only with XM_EXC_COUNT_EN)

## Operation
- Accept = in_valid & in_ready & ~flush. Pop = out_valid & out_ready.
- Remap applied on accept:
  - in_mult_exc=1 and in_aluop=6 → rd=30, result=4, wen=1.
  - Else in_div_exc=1 and in_aluop=7 → rd=30, result=5, wen=1. Mult takes priority if both are set.
  - Exception flags with any other in_aluop are ignored.
- wen is forced to 0 whenever the final rd is 0.
- Occupancy count is 0, 1, or 2. Head entry holds the oldest instruction; tail entry holds the second.
  - Accept only: count+1, write to the first free slot.
  - Pop only: count−1, tail shifts into head.
  - Accept and pop together: count unchanged; tail shifts to head and the new entry is written behind it.
- in_ready = (count_next < 2), registered. With count=2, in_ready=0 and no accept is possible.
- out_valid = (count != 0). The out_* signals drive the head entry and hold stable while out_valid & ~out_ready.
- flush: count → 0 next cycle; the same-cycle accept is dropped; a same-cycle pop still completes; in_ready=1 next cycle.

## Timing
- Reset values: out_valid=0, all out_* payload=0, in_ready=1, count=0, exc_count=0. Inputs are ignored while reset is high.
- Reset mid-operation discards all entries; the cycle after reset behaves as empty.
- Latency: with the stage empty, an entry accepted at edge N is visible on out_* after edge N, i.e. in cycle N+1.
- Throughput: 1 entry/cycle while out_ready is held high.
- First cycle with out_ready=0 while streaming: the in-flight entry lands in the tail; in_ready drops the following cycle.
- Releasing out_ready from full: in_ready returns to 1 one cycle after the first pop.

## Configuration
- XM_EXC_COUNT_EN defined:
  - exc_count exists.
  - Increments by 1 on each accept where a remap fired, saturating at all-ones.
  - Flush does not decrement; reset clears it.
- Undefined: the exc_count port and counter logic are absent; all other behaviour is identical.

## Structure
- Shared package xm_pkg holds:
  - RSTATUS_REG=5'd30, EXC_MULT=32'd4, EXC_DIV=32'd5
  - ALUOP_MULT=5'd6, ALUOP_DIV=5'd7
  - packed struct xm_entry_t {instr, result, store, rd, wen}
- One sub-module, xm_exc_remap: combinational remap plus rd=0 write suppression, producing xm_entry_t. Buffer and handshake logic stay in xm_stage.

## Test plan
- Stream 4 adds with out_ready=1 → each appears 1 cycle after accept, in order; in_ready stays 1; no bubbles.
- in_aluop=6, in_mult_exc=1, in_rd=7 → out_rd=30, out_result=4, out_wen=1; with XM_EXC_COUNT_EN, exc_count=1.
- in_aluop=7 with both exception flags set → out_result=4 (mult priority). in_aluop=0 with in_div_exc=1 → no remap.
- Hold out_ready=0 and offer 3 instructions → first 2 accepted, in_ready=0, third held off. Raise out_ready → pops in order; third accepted 1 cycle after the first pop.
- Full buffer, then flush with in_valid=1 → next cycle out_valid=0, in_ready=1, and the flushed-cycle instruction never appears.
- in_rd=0, in_wen=1 → out_wen=0. Assert reset with 2 entries held → out_valid=0 and in_ready=1 the next cycle.
